// File: rtl/core_pkg.sv
// Core-wide bus widths shared by the fetch and load/store paths.
package core_pkg;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH  = 64;
endpackage

// File: rtl/obi_arb_pkg.sv
// Types shared by the OBI memory arbiter and its outstanding-tag FIFO.
package obi_arb_pkg;
    typedef enum logic {SRC_IMEM, SRC_DMEM} obi_src_e;

    typedef struct packed {
        obi_src_e src;
        logic     word_sel;
    } obi_tag_t;
endpackage

// File: rtl/obi_tag_fifo.sv
// In-order FIFO of response tags; one entry per accepted address phase.
module obi_tag_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rstn_i,
    input  logic     push_i,
    input  logic     pop_i,
    input  obi_tag_t tag_i,
    output logic     full_o,
    output logic     empty_o,
    output obi_tag_t head_o
);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    obi_tag_t        mem_q [Depth];
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = do_pop  ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            if (do_push) begin
                mem_q[wptr_q] <= tag_i;
            end
        end
    end
endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one OBI memory port between instruction fetch and data access,
// with a round-robin address-phase arbiter and in-order response routing.
module obi_mem_arbiter
    import core_pkg::*;
    import obi_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          DmemFirst      = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    imem_req_i,
    output logic                    imem_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
    output logic                    imem_rvalid_o,
    output logic [INSTR_WIDTH-1:0]  imem_rdata_o,
    output logic                    imem_err_o,
    input  logic                    dmem_req_i,
    output logic                    dmem_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic                    dmem_we_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_be_i,
    output logic                    dmem_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
    output logic                    dmem_err_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_err_i
);
    localparam obi_src_e ResetPrio = DmemFirst ? SRC_DMEM : SRC_IMEM;

    logic     lock_q, lock_d;
    obi_src_e owner_q, owner_d, prio_q, prio_d, winner;
    logic     full, empty, accept, pop, resp_imem, resp_dmem;
    obi_tag_t push_tag, head;
    logic [INSTR_WIDTH-1:0] imem_word;

    // A locked owner keeps the port until granted so the address phase never changes.
    always_comb begin
        if (lock_q) begin
            winner = owner_q;
        end else if (imem_req_i && !dmem_req_i) begin
            winner = SRC_IMEM;
        end else if (dmem_req_i && !imem_req_i) begin
            winner = SRC_DMEM;
        end else begin
            winner = prio_q;
        end
    end

    assign mem_req_o  = rstn_i & (imem_req_i | dmem_req_i) & ~full;
    assign accept     = mem_req_o & mem_gnt_i;
    assign imem_gnt_o = accept & (winner == SRC_IMEM);
    assign dmem_gnt_o = accept & (winner == SRC_DMEM);

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (mem_req_o) begin
            if (winner == SRC_IMEM) begin
                mem_addr_o = imem_addr_i;
                mem_be_o   = '1;
            end else begin
                mem_addr_o  = dmem_addr_i;
                mem_we_o    = dmem_we_i;
                mem_wdata_o = dmem_wdata_i;
                mem_be_o    = dmem_be_i;
            end
        end
    end

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        if (accept) begin
            lock_d = 1'b0;
            prio_d = (winner == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
        end else if (mem_req_o) begin
            lock_d  = 1'b1;
            owner_d = winner;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lock_q  <= 1'b0;
            owner_q <= SRC_IMEM;
            prio_q  <= ResetPrio;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    assign push_tag.src      = winner;
    assign push_tag.word_sel = (winner == SRC_IMEM) ? imem_addr_i[2] : dmem_addr_i[2];

    obi_tag_fifo #(.Depth(MaxOutstanding)) u_tag_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (accept),
        .pop_i   (pop),
        .tag_i   (push_tag),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign pop       = mem_rvalid_i & ~empty;
    assign resp_imem = pop & (head.src == SRC_IMEM);
    assign resp_dmem = pop & (head.src == SRC_DMEM);

    // Fetches are 32-bit; on a 64-bit bus the address bit 2 captured at accept picks the half.
    if (DATA_WIDTH == 64) begin : g_wide
        assign imem_word = head.word_sel ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    end else begin : g_narrow
        assign imem_word = mem_rdata_i[INSTR_WIDTH-1:0];
    end

    assign imem_rvalid_o = resp_imem;
    assign imem_err_o    = resp_imem & mem_err_i;
    assign imem_rdata_o  = resp_imem ? imem_word : '0;
    assign dmem_rvalid_o = resp_dmem;
    assign dmem_err_o    = resp_dmem & mem_err_i;
    assign dmem_rdata_o  = resp_dmem ? mem_rdata_i : '0;

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rstn_i) mem_rvalid_i |-> !empty);
`endif
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed self-checking bench for obi_mem_arbiter (64-bit data, two outstanding).
module tb_obi_mem_arbiter;
    import core_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    rstn_i;
    logic                    imem_req_i, imem_gnt_o, imem_rvalid_o, imem_err_o;
    logic [ADDR_WIDTH-1:0]   imem_addr_i;
    logic [INSTR_WIDTH-1:0]  imem_rdata_o;
    logic                    dmem_req_i, dmem_gnt_o, dmem_we_i, dmem_rvalid_o, dmem_err_o;
    logic [ADDR_WIDTH-1:0]   dmem_addr_i;
    logic [DATA_WIDTH-1:0]   dmem_wdata_i, dmem_rdata_o;
    logic [DATA_WIDTH/8-1:0] dmem_be_i;
    logic                    mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
    logic [ADDR_WIDTH-1:0]   mem_addr_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o, mem_rdata_i;
    logic [DATA_WIDTH/8-1:0] mem_be_o;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk_i = ~clk_i;

    obi_mem_arbiter #(.MaxOutstanding(2), .DmemFirst(1'b1)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .imem_req_i(imem_req_i), .imem_gnt_o(imem_gnt_o), .imem_addr_i(imem_addr_i),
        .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o), .imem_err_o(imem_err_o),
        .dmem_req_i(dmem_req_i), .dmem_gnt_o(dmem_gnt_o), .dmem_addr_i(dmem_addr_i),
        .dmem_we_i(dmem_we_i), .dmem_wdata_i(dmem_wdata_i), .dmem_be_i(dmem_be_i),
        .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o), .dmem_err_o(dmem_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    task automatic clearInputs();
        imem_req_i = 1'b0; imem_addr_i = '0;
        dmem_req_i = 1'b0; dmem_addr_i = '0; dmem_we_i = 1'b0; dmem_wdata_i = '0; dmem_be_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clk_i);
        clearInputs();
        rstn_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    // Outputs must be quiet after reset with nothing requesting.
    task automatic test_reset();
        resetDut();
        #1;
        assertCount++; if (mem_req_o !== 1'b0) begin failCount++; $display("[TB] FAIL rst_mem_req: got %0h want 0", mem_req_o); end
        assertCount++; if ({imem_gnt_o, dmem_gnt_o, imem_rvalid_o, dmem_rvalid_o} !== 4'b0) begin failCount++; $display("[TB] FAIL rst_flags: got %b want 0000", {imem_gnt_o, dmem_gnt_o, imem_rvalid_o, dmem_rvalid_o}); end
        assertCount++; if (mem_addr_o !== '0 || mem_be_o !== '0) begin failCount++; $display("[TB] FAIL rst_addr_be: got %h/%h want 0/0", mem_addr_o, mem_be_o); end
    endtask

    // Single fetch from 0x104 returns the upper 32-bit half.
    task automatic test_single_fetch();
        resetDut();
        imem_req_i = 1'b1; imem_addr_i = 32'h104; mem_gnt_i = 1'b1;
        #1;
        assertCount++; if (imem_gnt_o !== 1'b1 || dmem_gnt_o !== 1'b0) begin failCount++; $display("[TB] FAIL t1_gnt: got i%0h d%0h want i1 d0", imem_gnt_o, dmem_gnt_o); end
        assertCount++; if (mem_addr_o !== 32'h104 || mem_we_o !== 1'b0 || mem_be_o !== 8'hFF || mem_wdata_o !== '0) begin failCount++; $display("[TB] FAIL t1_addr_phase: got %h %0h %h %h want 104 0 ff 0", mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o); end
        @(negedge clk_i);
        imem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hAAAABBBB_11112222;
        #1;
        assertCount++; if (imem_rvalid_o !== 1'b1 || dmem_rvalid_o !== 1'b0) begin failCount++; $display("[TB] FAIL t1_rvalid: got i%0h d%0h want i1 d0", imem_rvalid_o, dmem_rvalid_o); end
        assertCount++; if (imem_rdata_o !== 32'hAAAABBBB) begin failCount++; $display("[TB] FAIL t1_rdata: got %h want aaaabbbb", imem_rdata_o); end
        assertCount++; if (dmem_rdata_o !== '0) begin failCount++; $display("[TB] FAIL t1_dmem_rdata_gated: got %h want 0", dmem_rdata_o); end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        #1;
        assertCount++; if (imem_rvalid_o !== 1'b0) begin failCount++; $display("[TB] FAIL t1_rvalid_one_cycle: got %0h want 0", imem_rvalid_o); end
    endtask

    // Contested requests alternate dmem then imem; responses return in order.
    task automatic test_round_robin();
        resetDut();
        imem_req_i = 1'b1; imem_addr_i = 32'h10; dmem_req_i = 1'b1; dmem_addr_i = 32'h300; dmem_be_i = 8'hFF; mem_gnt_i = 1'b1;
        #1;
        assertCount++; if (dmem_gnt_o !== 1'b1 || imem_gnt_o !== 1'b0 || mem_addr_o !== 32'h300) begin failCount++; $display("[TB] FAIL t2_first_dmem: got d%0h i%0h a%h want d1 i0 a300", dmem_gnt_o, imem_gnt_o, mem_addr_o); end
        @(negedge clk_i);
        #1;
        assertCount++; if (imem_gnt_o !== 1'b1 || dmem_gnt_o !== 1'b0 || mem_addr_o !== 32'h10) begin failCount++; $display("[TB] FAIL t2_second_imem: got i%0h d%0h a%h want i1 d0 a10", imem_gnt_o, dmem_gnt_o, mem_addr_o); end
        @(negedge clk_i);
        imem_req_i = 1'b0; dmem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h01234567_89ABCDEF;
        #1;
        assertCount++; if (dmem_rvalid_o !== 1'b1 || imem_rvalid_o !== 1'b0 || dmem_rdata_o !== 64'h01234567_89ABCDEF) begin failCount++; $display("[TB] FAIL t2_resp_dmem: got d%0h i%0h %h want d1 i0 0123456789abcdef", dmem_rvalid_o, imem_rvalid_o, dmem_rdata_o); end
        @(negedge clk_i);
        mem_rdata_i = 64'hCAFEF00D_DEADBEEF;
        #1;
        assertCount++; if (imem_rvalid_o !== 1'b1 || dmem_rvalid_o !== 1'b0 || imem_rdata_o !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL t2_resp_imem: got i%0h d%0h %h want i1 d0 deadbeef", imem_rvalid_o, dmem_rvalid_o, imem_rdata_o); end
        @(negedge clk_i);
        clearInputs();
    endtask

    // A stalled dmem write keeps its address phase while imem waits.
    task automatic test_lock_stall();
        resetDut();
        dmem_req_i = 1'b1; dmem_addr_i = 32'h200; dmem_we_i = 1'b1; dmem_wdata_i = 64'h1234; dmem_be_i = 8'h0F;
        #1;
        assertCount++; if (mem_addr_o !== 32'h200 || mem_we_o !== 1'b1 || mem_be_o !== 8'h0F || mem_wdata_o !== 64'h1234) begin failCount++; $display("[TB] FAIL t3_c0_phase: got %h %0h %h %h want 200 1 0f 1234", mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o); end
        for (int c = 1; c < 3; c++) begin
            @(negedge clk_i);
            imem_req_i = 1'b1; imem_addr_i = 32'h40;
            #1;
            assertCount++; if (mem_addr_o !== 32'h200 || imem_gnt_o !== 1'b0 || dmem_gnt_o !== 1'b0) begin failCount++; $display("[TB] FAIL t3_stall_c%0d: got a%h i%0h d%0h want a200 i0 d0", c, mem_addr_o, imem_gnt_o, dmem_gnt_o); end
        end
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        #1;
        assertCount++; if (dmem_gnt_o !== 1'b1 || imem_gnt_o !== 1'b0 || mem_addr_o !== 32'h200) begin failCount++; $display("[TB] FAIL t3_grant_dmem: got d%0h i%0h a%h want d1 i0 a200", dmem_gnt_o, imem_gnt_o, mem_addr_o); end
        @(negedge clk_i);
        dmem_req_i = 1'b0;
        #1;
        assertCount++; if (imem_gnt_o !== 1'b1 || mem_addr_o !== 32'h40 || mem_we_o !== 1'b0 || mem_be_o !== 8'hFF || mem_wdata_o !== '0) begin failCount++; $display("[TB] FAIL t3_grant_imem: got i%0h a%h we%0h be%h wd%h want i1 a40 we0 beff wd0", imem_gnt_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o); end
        @(negedge clk_i);
        imem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        #1;
        assertCount++; if (dmem_rvalid_o !== 1'b1 || imem_rvalid_o !== 1'b0) begin failCount++; $display("[TB] FAIL t3_resp_dmem: got d%0h i%0h want d1 i0", dmem_rvalid_o, imem_rvalid_o); end
        @(negedge clk_i);
        #1;
        assertCount++; if (imem_rvalid_o !== 1'b1 || dmem_rvalid_o !== 1'b0) begin failCount++; $display("[TB] FAIL t3_resp_imem: got i%0h d%0h want i1 d0", imem_rvalid_o, dmem_rvalid_o); end
        @(negedge clk_i);
        clearInputs();
    endtask

    // A locked imem keeps the port even though dmem would win the round-robin pick.
    task automatic test_lock_owner();
        resetDut();
        imem_req_i = 1'b1; imem_addr_i = 32'h80;
        @(negedge clk_i);
        dmem_req_i = 1'b1; dmem_addr_i = 32'h90; mem_gnt_i = 1'b1;
        #1;
        assertCount++; if (imem_gnt_o !== 1'b1 || dmem_gnt_o !== 1'b0 || mem_addr_o !== 32'h80) begin failCount++; $display("[TB] FAIL t_lock_owner: got i%0h d%0h a%h want i1 d0 a80", imem_gnt_o, dmem_gnt_o, mem_addr_o); end
        @(negedge clk_i);
        imem_req_i = 1'b0;
        #1;
        assertCount++; if (dmem_gnt_o !== 1'b1 || mem_addr_o !== 32'h90) begin failCount++; $display("[TB] FAIL t_lock_release: got d%0h a%h want d1 a90", dmem_gnt_o, mem_addr_o); end
        @(negedge clk_i);
        dmem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        clearInputs();
    endtask

    // With two outstanding the request is held off, including in the popping cycle.
    task automatic test_full_fifo();
        resetDut();
        imem_req_i = 1'b1; imem_addr_i = 32'h8; mem_gnt_i = 1'b1;
        @(negedge clk_i);
        imem_req_i = 1'b0; dmem_req_i = 1'b1; dmem_addr_i = 32'h20; dmem_be_i = 8'hFF;
        @(negedge clk_i);
        imem_req_i = 1'b1;
        #1;
        assertCount++; if (mem_req_o !== 1'b0 || imem_gnt_o !== 1'b0 || dmem_gnt_o !== 1'b0 || mem_addr_o !== '0) begin failCount++; $display("[TB] FAIL t4_full_block: got r%0h i%0h d%0h a%h want r0 i0 d0 a0", mem_req_o, imem_gnt_o, dmem_gnt_o, mem_addr_o); end
        @(negedge clk_i);
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h55556666_77778888;
        #1;
        assertCount++; if (mem_req_o !== 1'b0 || imem_rvalid_o !== 1'b1 || imem_rdata_o !== 32'h77778888) begin failCount++; $display("[TB] FAIL t4_pop_while_full: got r%0h v%0h %h want r0 v1 77778888", mem_req_o, imem_rvalid_o, imem_rdata_o); end
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        #1;
        assertCount++; if (mem_req_o !== 1'b1 || imem_gnt_o !== 1'b1 || dmem_gnt_o !== 1'b0) begin failCount++; $display("[TB] FAIL t4_regrant: got r%0h i%0h d%0h want r1 i1 d0", mem_req_o, imem_gnt_o, dmem_gnt_o); end
        @(negedge clk_i);
        imem_req_i = 1'b0; dmem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        #1;
        assertCount++; if (dmem_rvalid_o !== 1'b1 || imem_rvalid_o !== 1'b0) begin failCount++; $display("[TB] FAIL t4_drain_dmem: got d%0h i%0h want d1 i0", dmem_rvalid_o, imem_rvalid_o); end
        @(negedge clk_i);
        #1;
        assertCount++; if (imem_rvalid_o !== 1'b1) begin failCount++; $display("[TB] FAIL t4_drain_imem: got %0h want 1", imem_rvalid_o); end
        @(negedge clk_i);
        clearInputs();
    endtask

    // Error response is routed only to the data port.
    task automatic test_error_response();
        resetDut();
        dmem_req_i = 1'b1; dmem_addr_i = 32'h400; dmem_be_i = 8'hFF; mem_gnt_i = 1'b1;
        @(negedge clk_i);
        dmem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b1;
        #1;
        assertCount++; if (dmem_rvalid_o !== 1'b1 || dmem_err_o !== 1'b1) begin failCount++; $display("[TB] FAIL t5_dmem_err: got v%0h e%0h want v1 e1", dmem_rvalid_o, dmem_err_o); end
        assertCount++; if (imem_err_o !== 1'b0 || imem_rvalid_o !== 1'b0) begin failCount++; $display("[TB] FAIL t5_imem_quiet: got v%0h e%0h want v0 e0", imem_rvalid_o, imem_err_o); end
        @(negedge clk_i);
        clearInputs();
    endtask

    // Reset mid-cycle with traffic pending; priority and FIFO must start clean.
    task automatic test_reset_midflight();
        resetDut();
        dmem_req_i = 1'b1; dmem_addr_i = 32'h60; dmem_be_i = 8'hFF; mem_gnt_i = 1'b1;
        @(negedge clk_i);
        dmem_req_i = 1'b0; mem_gnt_i = 1'b0; imem_req_i = 1'b1; imem_addr_i = 32'h4;
        @(negedge clk_i);
        dmem_req_i = 1'b1;
        #1;
        assertCount++; if (mem_addr_o !== 32'h4) begin failCount++; $display("[TB] FAIL t6_locked_imem: got %h want 4", mem_addr_o); end
        #1;
        rstn_i = 1'b0; mem_gnt_i = 1'b1;
        #1;
        assertCount++; if (mem_req_o !== 1'b0 || imem_gnt_o !== 1'b0 || dmem_gnt_o !== 1'b0 || mem_addr_o !== '0 || mem_be_o !== '0) begin failCount++; $display("[TB] FAIL t6_reset_outputs: got r%0h i%0h d%0h a%h be%h want all 0", mem_req_o, imem_gnt_o, dmem_gnt_o, mem_addr_o, mem_be_o); end
        @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        assertCount++; if (dmem_gnt_o !== 1'b1 || imem_gnt_o !== 1'b0) begin failCount++; $display("[TB] FAIL t6_first_after_reset: got d%0h i%0h want d1 i0", dmem_gnt_o, imem_gnt_o); end
        @(negedge clk_i);
        #1;
        assertCount++; if (imem_gnt_o !== 1'b1 || mem_req_o !== 1'b1) begin failCount++; $display("[TB] FAIL t6_fifo_cleared: got i%0h r%0h want i1 r1", imem_gnt_o, mem_req_o); end
        @(negedge clk_i);
        imem_req_i = 1'b0; dmem_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        #1;
        assertCount++; if (dmem_rvalid_o !== 1'b1) begin failCount++; $display("[TB] FAIL t6_resp_order: got %0h want 1", dmem_rvalid_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        clearInputs();
    endtask

    initial begin
        rstn_i = 1'b0;
        clearInputs();
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_lock_stall();
        test_lock_owner();
        test_full_fifo();
        test_error_response();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
